// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_seq_state_t;

    localparam int LOL_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchroniser bringing the PLL locked flag into the refclk domain.
module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: sequences PLL reset, qualifies lock, and gates the system reset on stable lock.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter  int RST_HOLD_CYCLES     = 16,
    parameter  int LOCK_STABLE_CYCLES  = 1024,
    parameter  int LOCK_TIMEOUT_CYCLES = 50000,
    parameter  int MAX_RETRIES         = 3,
    localparam int RC_W                = $clog2(MAX_RETRIES + 1)
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic                 restart_req,
    output logic                 pll_rst,
    output logic                 sys_rst,
    output logic                 ready,
    output logic                 fault,
    output logic [2:0]           state,
    output logic [RC_W-1:0]      retry_cnt,
    output logic [LOL_CNT_W-1:0] lol_count
);

    localparam int CNT_MAX = max3(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic                 lk;
    pll_seq_state_t       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RC_W-1:0]      retry_q, retry_d;
    logic [LOL_CNT_W-1:0] lol_q, lol_d;
    logic                 pll_rst_q, sys_rst_q, ready_q, fault_q;

    pll_lock_sync u_sync (
        .clk_i   (refclk),
        .rst_i   (rst),
        .async_i (pll_locked),
        .sync_o  (lk)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lol_d   = lol_q;
        case (state_q)
            HOLD:      if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    state_d = (retry_q == RC_W'(MAX_RETRIES)) ? FAULT : HOLD;
                    retry_d = (retry_q == RC_W'(MAX_RETRIES)) ? retry_q : retry_q + 1'b1;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            // Loss of lock is counted even when a restart arrives on the same edge.
            RUN: begin
                if (!lk) begin
                    state_d = HOLD;
                    lol_d   = lol_q + LOL_CNT_W'(lol_q != '1);
                end else if (restart_req) begin
                    state_d = HOLD;
                end
            end
            FAULT: begin
                if (restart_req) begin
                    state_d = HOLD;
                    retry_d = '0;
                end
            end
            default: state_d = HOLD;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            retry_q   <= '0;
            lol_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lol_q     <= lol_d;
            pll_rst_q <= (state_d == HOLD) || (state_d == FAULT);
            sys_rst_q <= state_d != RUN;
            ready_q   <= state_d == RUN;
            fault_q   <= state_d == FAULT;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign state     = state_q;
    assign retry_cnt = retry_q;
    assign lol_count = lol_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scenarios plus random lock/restart traffic against a timeline model.
module tb_pll_lock_sequencer;

    localparam int RH = 4;
    localparam int ST = 8;
    localparam int TO = 32;
    localparam int MR = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] lol_count;

    int n_chk = 0;
    int n_fail = 0;
    int m_state, m_retry, m_lol, cyc, t_enter;
    bit m_s1, m_s2;

    always #5 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES     (RH),
        .LOCK_STABLE_CYCLES  (ST),
        .LOCK_TIMEOUT_CYCLES (TO),
        .MAX_RETRIES         (MR)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .restart_req (restart_req),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fault       (fault),
        .state       (state),
        .retry_cnt   (retry_cnt),
        .lol_count   (lol_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_retry = 0; m_lol = 0;
        m_s1 = 0; m_s2 = 0; cyc = 0; t_enter = 0;
    endtask

    // Time-in-phase is the number of edges since the phase was entered.
    task automatic model_step(input bit l, input bit r);
        int el = cyc - t_enter;
        int nxt = m_state;
        bit locked_seen = m_s2;
        if (m_state == 0) begin
            if (el == RH - 1) nxt = 1;
        end else if (m_state == 1) begin
            if (locked_seen) nxt = 2;
            else if (el == TO - 1) begin
                if (m_retry == MR) nxt = 4;
                else begin m_retry++; nxt = 0; end
            end
        end else if (m_state == 2) begin
            if (!locked_seen) nxt = 1;
            else if (el == ST - 1) begin nxt = 3; m_retry = 0; end
        end else if (m_state == 3) begin
            if (!locked_seen) begin nxt = 0; m_lol = (m_lol < 255) ? m_lol + 1 : 255; end
            else if (r) nxt = 0;
        end else begin
            if (r) begin nxt = 0; m_retry = 0; end
        end
        m_s2 = m_s1;
        m_s1 = l;
        cyc++;
        if (nxt != m_state) t_enter = cyc;
        m_state = nxt;
    endtask

    task automatic compare_all();
        chk("state", state, m_state);
        chk("pll_rst", pll_rst, int'(m_state == 0 || m_state == 4));
        chk("sys_rst", sys_rst, int'(m_state != 3));
        chk("ready", ready, int'(m_state == 3));
        chk("fault", fault, int'(m_state == 4));
        chk("retry_cnt", retry_cnt, m_retry);
        chk("lol_count", lol_count, m_lol);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input bit l, input bit r);
        pll_locked = l;
        restart_req = r;
        @(posedge refclk);
        model_step(l, r);
        #1;
        compare_all();
        @(negedge refclk);
    endtask

    task automatic async_rst(input string tag, input bit l);
        int hold = 0;
        #2 rst = 1'b1;
        #1;
        chk({tag, "_rst_state"}, state, 0);
        chk({tag, "_rst_pll_rst"}, pll_rst, 1);
        chk({tag, "_rst_sys_rst"}, sys_rst, 1);
        chk({tag, "_rst_ready"}, ready, 0);
        chk({tag, "_rst_fault"}, fault, 0);
        chk({tag, "_rst_retry"}, retry_cnt, 0);
        chk({tag, "_rst_lol"}, lol_count, 0);
        model_reset();
        @(negedge refclk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (pll_rst) hold++;
            tick(l, 0);
        end
        chk({tag, "_hold_len"}, hold, RH);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hold, first, n;
        model_reset();
        #12;
        chk("reset_state", state, 0);
        chk("reset_pll_rst", pll_rst, 1);
        chk("reset_sys_rst", sys_rst, 1);
        chk("reset_ready", ready, 0);
        chk("reset_fault", fault, 0);
        chk("reset_retry", retry_cnt, 0);
        chk("reset_lol", lol_count, 0);
        @(negedge refclk);
        rst = 1'b0;

        hold = 0;
        for (int i = 0; i < 10; i++) begin
            if (pll_rst) hold++;
            tick(0, 0);
        end
        chk("clean_hold_len", hold, RH);
        tick(1, 0);
        tick(1, 0);
        chk("clean_pre_stable", state, 1);
        tick(1, 0);
        chk("clean_stable_lat", state, 2);
        for (int i = 0; i < ST - 1; i++) tick(1, 0);
        chk("clean_not_ready", ready, 0);
        tick(1, 0);
        chk("clean_ready", ready, 1);
        chk("clean_sys_rst", sys_rst, 0);
        chk("clean_retry", retry_cnt, 0);

        async_rst("timeout", 0);
        first = -1;
        for (int i = 9; i <= 120; i++) begin
            tick(0, 0);
            if (i == 36) chk("timeout_retry1", retry_cnt, 1);
            if (i == 72) chk("timeout_retry2", retry_cnt, 2);
            if (fault && first < 0) first = i;
        end
        chk("timeout_fault_cyc", first, 3 * (RH + TO));
        chk("timeout_pll_rst", pll_rst, 1);
        tick(0, 1);
        chk("fault_restart_state", state, 0);
        chk("fault_restart_retry", retry_cnt, 0);
        for (int i = 0; i < 3 * (RH + TO); i++) tick(0, 0);
        chk("fault_again", fault, 1);
        async_rst("fault", 0);

        for (int i = 0; i < 60 && m_retry != 1; i++) tick(0, 0);
        chk("glitch_pre_retry", retry_cnt, 1);
        for (int i = 0; i < 20 && m_state != 2; i++) tick(1, 0);
        chk("glitch_in_stable", state, 2);
        for (int i = 0; i < 5; i++) tick(1, 0);
        for (int i = 0; i < 3; i++) tick(0, 0);
        chk("glitch_back_wait", state, 1);
        chk("glitch_retry", retry_cnt, 1);
        n = 0;
        for (int i = 0; i < 30 && !ready; i++) begin
            tick(1, 0);
            n++;
        end
        chk("glitch_relock_len", n, 3 + ST);

        tick(0, 0);
        tick(0, 0);
        tick(0, 1);
        chk("simul_state", state, 0);
        chk("simul_lol", lol_count, 1);
        for (int i = 0; i < 10 && m_state != 1; i++) tick(0, 0);
        tick(0, 1);
        chk("wait_req_ignored", state, 1);
        for (int i = 0; i < 60 && m_retry != 1; i++) tick(0, 0);
        chk("wait_req_timeout", retry_cnt, 1);

        for (int i = 0; i < 40 && m_state != 3; i++) tick(1, 0);
        chk("lol_start_run", state, 3);
        for (int k = 0; k < 260; k++) begin
            for (int i = 0; i < 3; i++) tick(0, 0);
            if (k == 0) begin
                chk("lol_ready", ready, 0);
                chk("lol_sys_rst", sys_rst, 1);
                chk("lol_state", state, 0);
                chk("lol_count1", lol_count, 2);
            end
            for (int i = 0; i < 40 && m_state != 3; i++) tick(1, 0);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick(1, 0);
        end
        chk("lol_sat", lol_count, 255);

        for (int s = 0; s < 40; s++) begin
            bit l = ($urandom_range(0, 3) != 0);
            int len = $urandom_range(1, 50);
            for (int i = 0; i < len; i++) tick(l, $urandom_range(0, 15) == 0);
        end

        tick(1, 1);
        for (int i = 0; i < 60 && m_state != 2; i++) tick(1, 0);
        tick(1, 0);
        chk("stable_before_rst", state, 2);
        async_rst("stable", 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
